cartesian_issue_sched: RTL and testbench
========================================

CARTESIAN_ISSUE_SCHED -- requirements
Module: cartesian_issue_sched

Interface
REQ-001 SHALL have parameter I, default 4: activation lanes issued per cycle.
REQ-002 SHALL have parameter F, default 4: weight lanes issued per cycle.
REQ-003 SHALL have parameter MAX_NZ, default 256: maximum nonzero count per operand stream.
REQ-004 SHALL have parameter MAX_KG, default 16: maximum Kc groups per tile.
REQ-005 SHALL have parameter DRAIN, default 2: cycles waited after the last issue before done.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1: one-cycle pulse that begins a tile; sampled only in IDLE.
REQ-009 SHALL have port num_act, input, clog2(MAX_NZ)+1: nonzero activations in the tile; latched at start.
REQ-010 SHALL have port num_wt, input, clog2(MAX_NZ)+1: nonzero weights per Kc group; latched at start.
REQ-011 SHALL have port num_kg, input, clog2(MAX_KG)+1: Kc groups in the tile; latched at start.
REQ-012 SHALL have port ds_stall, input, 1: downstream (crossbar/accumulator) backpressure.
REQ-013 SHALL have port stall, output, 1: freeze to the coordinate datapath and index decoders.
REQ-014 SHALL have port decode_restart, output, 1: rewinds the activation index decoder.
REQ-015 SHALL have port next_a, output, 1: advance the activation decoder to the next I-group.
REQ-016 SHALL have port first_Ex_state_cycle, output, 1: first issue cycle of a Kc group.
REQ-017 SHALL have port K_changing, output, 1: last issue cycle of a Kc group.
REQ-018 SHALL have port act_mask, output, I: lane-valid mask for the current activation group.
REQ-019 SHALL have port wt_mask, output, F: lane-valid mask for the current weight group.
REQ-020 SHALL have port issue_valid, output, 1: an I x F product is issued this cycle.
REQ-021 SHALL have ports busy and done, output, 1 each: busy means not in IDLE; done is a one-cycle pulse at tile end.

Function
REQ-022 SHALL implement FSM states IDLE, RESTART, EXEC, KSWITCH, DRAIN, DONE.
REQ-023 SHALL go IDLE->RESTART on start; if num_act, num_wt or num_kg is 0, it SHALL go IDLE->DONE instead and never assert issue_valid.
REQ-024 RESTART SHALL last exactly one cycle with decode_restart=1, then go to EXEC.
REQ-025 In EXEC, loop order SHALL be Kc group (outer), activation group ag in 0..ceil(num_act/I)-1, weight group wg in 0..ceil(num_wt/F)-1 (inner).
REQ-026 Each non-stalled EXEC cycle SHALL assert issue_valid and advance wg by one.
REQ-027 next_a SHALL be 1 on the cycle wg is at its last value, and ag SHALL advance on that cycle.
REQ-028 first_Ex_state_cycle SHALL be 1 on the first issue cycle of each Kc group.
REQ-029 K_changing SHALL be 1 on the cycle ag and wg are both at their last values; the FSM SHALL then go to KSWITCH if more Kc groups remain, else to DRAIN.
REQ-030 KSWITCH SHALL last one cycle with decode_restart=1 and issue_valid=0, increment the Kc counter, clear ag and wg, and return to EXEC.
REQ-031 act_mask bit n SHALL be 1 iff ag*I+n < num_act; wt_mask bit n SHALL be 1 iff wg*F+n < num_wt. A partial final group SHALL give a partial mask.
REQ-032 stall SHALL equal ds_stall whenever busy; while stall=1, counters, FSM state and all outputs SHALL hold their values.
REQ-033 DRAIN SHALL count DRAIN non-stalled cycles, then go to DONE; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-034 start outside IDLE SHALL be ignored.
REQ-035 Total issue cycles SHALL equal num_kg*ceil(num_act/I)*ceil(num_wt/F), excluding stalled cycles.
REQ-036 Counter widths SHALL be sized for the maximum values, with no wrap within a legal tile.

Reset
REQ-037 While rst_n=0: state=IDLE, all counters=0, and all outputs=0, asynchronously.
REQ-038 Reset asserted mid-tile SHALL abort the tile with no done pulse; after release the block SHALL wait for a new start.

Structure
REQ-039 The FSM state enum and defaults for I, F, MAX_NZ and MAX_KG SHALL live in the shared package, alongside the existing I/F/Kc defines.
REQ-040 Lane-mask generation SHALL be one sub-module, lane_mask_gen (count, group index -> mask), instantiated twice.

Verification
REQ-041 num_act=8, num_wt=8, num_kg=1, I=F=4, no stall -> 4 issue cycles; next_a on cycles 2 and 4; K_changing on cycle 4; done 2 cycles after DRAIN entry.
REQ-042 num_act=5, num_wt=3, num_kg=2 -> act_mask 1111 then 0001, wt_mask 0111; 4 issues; one KSWITCH cycle with decode_restart=1 between Kc groups.
REQ-043 num_wt=0 with start -> done on the cycle after start; issue_valid never asserted.
REQ-044 ds_stall held for 3 cycles mid-EXEC -> outputs frozen; total issue count unchanged at 4 for the REQ-041 setup.
REQ-045 rst_n pulsed low mid-EXEC -> all outputs 0 immediately, no done pulse; a fresh start then completes normally.
REQ-046 start pulsed while busy -> ignored; exactly one done pulse for the tile.

Source files
------------

// File: rtl/cartesian_issue_sched_pkg.sv
// rtl/cartesian_issue_sched_pkg.sv - shared defaults and FSM state encoding for the issue scheduler
// Purpose: lane/Kc default sizes and the scheduler state type, imported by
//          cartesian_issue_sched and lane_mask_gen.
// Ports:   none (package).
package cartesian_issue_sched_pkg;

  // Datapath geometry defaults (activation lanes, weight lanes, Kc grouping).
  localparam int DEF_I      = 4;
  localparam int DEF_F      = 4;
  localparam int DEF_KC     = 4;
  localparam int DEF_MAX_NZ = 256;
  localparam int DEF_MAX_KG = 16;
  localparam int DEF_DRAIN  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_EXEC    = 3'd2,
    ST_KSWITCH = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/cartesian_issue_sched_lane_mask_gen.sv
// rtl/cartesian_issue_sched_lane_mask_gen.sv - lane-valid mask for one operand group
// Purpose: mask bit n is set when lane n of group grp holds a real element,
//          i.e. grp*LANES + n < count.
// Ports:   count (total nonzero elements), grp (current group index),
//          mask (LANES-wide lane-valid output).
module lane_mask_gen
  import cartesian_issue_sched_pkg::*;
#(
  parameter int LANES = DEF_I,
  parameter int CW    = 9,
  parameter int GW    = 9
) (
  input  logic [CW-1:0]    count,
  input  logic [GW-1:0]    grp,
  output logic [LANES-1:0] mask
);

  // 32-bit arithmetic keeps grp*LANES+n from wrapping for any legal size.
  always_comb begin
    mask = '0;
    for (int n = 0; n < LANES; n++) begin
      mask[n] = ((32'(grp) * 32'(LANES)) + 32'(n)) < 32'(count);
    end
  end

endmodule

// File: rtl/cartesian_issue_sched.sv
// rtl/cartesian_issue_sched.sv - Cartesian-product issue scheduler for a sparse I x F multiplier array
// Purpose: walks Kc group (outer), activation group, weight group (inner),
//          issuing one I x F product per non-stalled EXEC cycle.
// Ports:   clk, rst_n (async active-low)
//          start, num_act, num_wt, num_kg  - tile launch and sizes (latched at start)
//          ds_stall                        - downstream backpressure
//          stall, decode_restart, next_a   - decoder/datapath control
//          first_Ex_state_cycle, K_changing- Kc group boundary markers
//          act_mask, wt_mask, issue_valid  - issue qualifiers
//          busy, done                      - status
module cartesian_issue_sched
  import cartesian_issue_sched_pkg::*;
#(
  parameter int I      = DEF_I,
  parameter int F      = DEF_F,
  parameter int MAX_NZ = DEF_MAX_NZ,
  parameter int MAX_KG = DEF_MAX_KG,
  parameter int DRAIN  = DEF_DRAIN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(MAX_NZ):0]     num_act,
  input  logic [$clog2(MAX_NZ):0]     num_wt,
  input  logic [$clog2(MAX_KG):0]     num_kg,
  input  logic                        ds_stall,
  output logic                        stall,
  output logic                        decode_restart,
  output logic                        next_a,
  output logic                        first_Ex_state_cycle,
  output logic                        K_changing,
  output logic [I-1:0]                act_mask,
  output logic [F-1:0]                wt_mask,
  output logic                        issue_valid,
  output logic                        busy,
  output logic                        done
);

  localparam int NW = $clog2(MAX_NZ) + 1;
  localparam int KW = $clog2(MAX_KG) + 1;
  localparam int DW = $clog2(DRAIN + 1) + 1;

  localparam logic [NW:0] I_W  = (NW + 1)'(I);
  localparam logic [NW:0] F_W  = (NW + 1)'(F);
  localparam logic [NW:0] I_M1 = (NW + 1)'(I - 1);
  localparam logic [NW:0] F_M1 = (NW + 1)'(F - 1);

  state_t          state;
  logic [NW-1:0]   act_cnt, wt_cnt;   // latched element counts
  logic [NW-1:0]   ag_num, wg_num;    // latched group counts
  logic [KW-1:0]   kg_num;
  logic [NW-1:0]   ag, wg;
  logic [KW-1:0]   kc;
  logic [DW-1:0]   dcnt;

  logic [NW:0]     act_sum, wt_sum;
  logic [NW-1:0]   act_grps, wt_grps;
  logic            empty_tile;
  logic            wg_last, ag_last, kc_last, in_exec;
  logic [I-1:0]    act_mask_raw;
  logic [F-1:0]    wt_mask_raw;

  // Group counts are ceil(count/lanes); one extra bit absorbs the rounding add.
  assign act_sum    = {1'b0, num_act} + I_M1;
  assign wt_sum     = {1'b0, num_wt} + F_M1;
  assign act_grps   = NW'(act_sum / I_W);
  assign wt_grps    = NW'(wt_sum / F_W);
  assign empty_tile = (num_act == '0) || (num_wt == '0) || (num_kg == '0);

  assign in_exec = (state == ST_EXEC);
  assign wg_last = (wg == wg_num - NW'(1));
  assign ag_last = (ag == ag_num - NW'(1));
  assign kc_last = (kc == kg_num - KW'(1));

  // All outputs decode from registered state, so freezing the registers
  // under stall freezes every output except stall itself.
  assign busy                 = (state != ST_IDLE);
  assign stall                = busy & ds_stall;
  assign done                 = (state == ST_DONE);
  assign decode_restart       = (state == ST_RESTART) || (state == ST_KSWITCH);
  assign issue_valid          = in_exec;
  assign next_a               = in_exec & wg_last;
  assign K_changing           = in_exec & wg_last & ag_last;
  assign first_Ex_state_cycle = in_exec & (ag == '0) & (wg == '0);
  assign act_mask             = act_mask_raw & {I{in_exec}};
  assign wt_mask              = wt_mask_raw & {F{in_exec}};

  lane_mask_gen #(.LANES(I), .CW(NW), .GW(NW)) u_act_mask (
    .count (act_cnt),
    .grp   (ag),
    .mask  (act_mask_raw)
  );

  lane_mask_gen #(.LANES(F), .CW(NW), .GW(NW)) u_wt_mask (
    .count (wt_cnt),
    .grp   (wg),
    .mask  (wt_mask_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      act_cnt <= '0;
      wt_cnt  <= '0;
      ag_num  <= '0;
      wg_num  <= '0;
      kg_num  <= '0;
      ag      <= '0;
      wg      <= '0;
      kc      <= '0;
      dcnt    <= '0;
    end else if (!stall) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            act_cnt <= num_act;
            wt_cnt  <= num_wt;
            ag_num  <= act_grps;
            wg_num  <= wt_grps;
            kg_num  <= num_kg;
            ag      <= '0;
            wg      <= '0;
            kc      <= '0;
            dcnt    <= '0;
            state   <= empty_tile ? ST_DONE : ST_RESTART;
          end
        end
        ST_RESTART: state <= ST_EXEC;
        ST_EXEC: begin
          if (wg_last) begin
            wg <= '0;
            if (ag_last) begin
              state <= kc_last ? ST_DRAIN : ST_KSWITCH;
            end else begin
              ag <= ag + NW'(1);
            end
          end else begin
            wg <= wg + NW'(1);
          end
        end
        ST_KSWITCH: begin
          kc    <= kc + KW'(1);
          ag    <= '0;
          wg    <= '0;
          state <= ST_EXEC;
        end
        ST_DRAIN: begin
          // Covers in-flight products in the crossbar/accumulator pipeline.
          if ((32'(dcnt) + 32'd1) >= 32'(DRAIN)) begin
            state <= ST_DONE;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        ST_DONE: begin
          dcnt  <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cartesian_issue_sched.sv
// tb/tb_cartesian_issue_sched.sv - scoreboard bench for cartesian_issue_sched
module tb_cartesian_issue_sched;

  localparam int I = 4, F = 4, MAX_NZ = 256, MAX_KG = 16, DRAIN = 2;
  localparam int NW = $clog2(MAX_NZ) + 1;
  localparam int KW = $clog2(MAX_KG) + 1;

  logic          clk, rst_n, start, ds_stall;
  logic [NW-1:0] num_act, num_wt;
  logic [KW-1:0] num_kg;
  logic          stall, decode_restart, next_a, first_Ex_state_cycle, K_changing;
  logic [I-1:0]  act_mask;
  logic [F-1:0]  wt_mask;
  logic          issue_valid, busy, done;

  cartesian_issue_sched #(.I(I), .F(F), .MAX_NZ(MAX_NZ), .MAX_KG(MAX_KG), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_act(num_act), .num_wt(num_wt),
    .num_kg(num_kg), .ds_stall(ds_stall), .stall(stall), .decode_restart(decode_restart),
    .next_a(next_a), .first_Ex_state_cycle(first_Ex_state_cycle), .K_changing(K_changing),
    .act_mask(act_mask), .wt_mask(wt_mask), .issue_valid(issue_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  int issue_cnt = 0, done_cnt = 0, restart_cnt = 0;
  int start_cyc = 0, last_issue_cyc = 0, done_cyc = 0;
  logic [10:0] sb[$];
  logic [14:0] prev_snap;
  logic        prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected issue stream: {act_mask, wt_mask, next_a, first, K_changing}.
  task automatic push_tile(input int na, input int nw, input int nk);
    int agn, wgn;
    logic [I-1:0] am;
    logic [F-1:0] wm;
    agn = (na + I - 1) / I;
    wgn = (nw + F - 1) / F;
    if (na == 0 || nw == 0 || nk == 0) return;
    for (int k = 0; k < nk; k++)
      for (int a = 0; a < agn; a++)
        for (int w = 0; w < wgn; w++) begin
          for (int n = 0; n < I; n++) am[n] = (a * I + n) < na;
          for (int n = 0; n < F; n++) wm[n] = (w * F + n) < nw;
          sb.push_back({am, wm, w == wgn - 1, a == 0 && w == 0, (w == wgn - 1) && (a == agn - 1)});
        end
  endtask

  always @(negedge clk) begin
    logic [10:0] obs, exp;
    logic [14:0] snap;
    if (rst_n) begin
      obs  = {act_mask, wt_mask, next_a, first_Ex_state_cycle, K_changing};
      snap = {obs, issue_valid, decode_restart, busy, done};
      if (busy) chk("stall_follows_ds_stall", stall, ds_stall);
      if (stall && prev_stall) chk("frozen_under_stall", snap, prev_snap);
      if (issue_valid && !stall) begin
        issue_cnt++;
        last_issue_cyc = cyc;
        chk("issue_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          chk("issue_fields", obs, exp);
        end
      end
      if (decode_restart && !stall) begin
        restart_cnt++;
        chk("no_issue_on_restart", issue_valid, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (start && !busy) start_cyc = cyc;
      prev_stall = stall;
      prev_snap  = snap;
    end else begin
      prev_stall = 1'b0;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tile(input int na, input int nw, input int nk,
                          input int stall_at, input int stall_len, input int pulse_at);
    int exp_issues;
    exp_issues = nk * ((na + I - 1) / I) * ((nw + F - 1) / F);
    issue_cnt = 0; done_cnt = 0; restart_cnt = 0;
    push_tile(na, nw, nk);
    step();
    num_act = NW'(na); num_wt = NW'(nw); num_kg = KW'(nk); start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (i == stall_at) ds_stall = 1'b1;
      if (i == stall_at + stall_len) ds_stall = 1'b0;
      start = (i == pulse_at);
      step();
      if (done_cnt > 0) break;
    end
    start = 1'b0;
    ds_stall = 1'b0;
    chk("done_within_budget", done_cnt > 0, 1);
    repeat (4) step();
    chk("single_done", done_cnt, 1);
    chk("issue_total", issue_cnt, exp_issues);
    chk("scoreboard_drained", sb.size(), 0);
    chk("restart_count", restart_cnt, (exp_issues == 0) ? 0 : nk);
    chk("idle_after_tile", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ds_stall = 1'b1;
    num_act = '0; num_wt = '0; num_kg = '0;
    #1;
    chk("reset_outputs", {stall, decode_restart, next_a, first_Ex_state_cycle, K_changing,
                          act_mask, wt_mask, issue_valid, busy, done}, 0);
    repeat (2) step();
    rst_n = 1'b1; ds_stall = 1'b0;
    repeat (2) step();

    run_tile(8, 8, 1, -1, 0, -1);
    chk("drain_latency", done_cyc - last_issue_cyc, DRAIN + 1);

    run_tile(5, 3, 2, -1, 0, -1);

    run_tile(4, 0, 1, -1, 0, -1);
    chk("empty_done_latency", done_cyc - start_cyc, 1);

    run_tile(8, 8, 1, 2, 3, -1);

    // Abort a long tile mid-EXEC with an asynchronous reset.
    issue_cnt = 0;
    push_tile(16, 16, 1);
    step();
    num_act = NW'(16); num_wt = NW'(16); num_kg = KW'(1); start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("mid_exec_before_reset", issue_valid, 1);
    ds_stall = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {stall, decode_restart, next_a, first_Ex_state_cycle, K_changing,
                                act_mask, wt_mask, issue_valid, busy, done}, 0);
    repeat (2) step();
    sb.delete();
    done_cnt = 0;
    rst_n = 1'b1; ds_stall = 1'b0;
    repeat (6) step();
    chk("no_done_after_abort", done_cnt, 0);
    chk("waits_for_start", busy, 0);

    run_tile(8, 8, 1, -1, 0, -1);
    run_tile(5, 3, 2, -1, 0, 3);
    run_tile(3, 9, 3, 4, 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
